// File: rtl/token_sequencer.sv
// token_sequencer: packs tokenizer bytes into tokens (word/number/line-end) for a parser.
// Latency: o_valid rises one cycle after the edge that processes the WC/EOL byte.
// Backpressure: o_valid/outputs held stable and o_next held low until i_accept; i_en=0 freezes all.
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_en (freeze when 0)
//   tokenizer side : o_next (fetch request), i_tok_ready, i_tok_data, i_tok_eol, i_tok_wc
//   parser side    : o_valid, i_accept, o_word, o_len, o_is_num, o_num, o_eol, o_trunc
// Build option: define TOKEN_SEQUENCER_NEG_NUM_EN to treat a leading '-' as a numeric sign.
module token_sequencer #(
  parameter int MAXLEN    = 8,
  parameter int NUM_WIDTH = 32,
  localparam int LW       = $clog2(MAXLEN + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  output logic                  o_next,
  input  logic                  i_tok_ready,
  input  logic [7:0]            i_tok_data,
  input  logic                  i_tok_eol,
  input  logic                  i_tok_wc,
  output logic                  o_valid,
  input  logic                  i_accept,
  output logic [8*MAXLEN-1:0]   o_word,
  output logic [LW-1:0]         o_len,
  output logic                  o_is_num,
  output logic [NUM_WIDTH-1:0]  o_num,
  output logic                  o_eol,
  output logic                  o_trunc
);

  typedef enum logic [1:0] {FETCH, ACK, EMIT} state_t;

  state_t               state_q, state_d;
  logic                 next_q, next_d;
  logic [7:0]           cap_dat_q, cap_dat_d;
  logic                 cap_eol_q, cap_eol_d;
  logic                 cap_wc_q, cap_wc_d;
  logic [8*MAXLEN-1:0]  word_q, word_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 seen_q, seen_d;     // any data byte this token, stored or dropped
  logic                 digit_q, digit_d;   // at least one digit this token
  logic                 is_num_q, is_num_d; // no disqualifying character seen yet
  logic [NUM_WIDTH-1:0] num_q, num_d;
  logic                 eol_q, eol_d;
  logic                 trunc_q, trunc_d;
  logic                 valid_q, valid_d;
`ifdef TOKEN_SEQUENCER_NEG_NUM_EN
  logic                 neg_q, neg_d;
`endif

  logic                 is_digit;
  logic [NUM_WIDTH-1:0] digit_val;

  assign is_digit  = (cap_dat_q >= 8'h30) && (cap_dat_q <= 8'h39);
  assign digit_val = NUM_WIDTH'(cap_dat_q[3:0]);

  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    cap_dat_d = cap_dat_q;
    cap_eol_d = cap_eol_q;
    cap_wc_d  = cap_wc_q;
    word_d    = word_q;
    len_d     = len_q;
    seen_d    = seen_q;
    digit_d   = digit_q;
    is_num_d  = is_num_q;
    num_d     = num_q;
    eol_d     = eol_q;
    trunc_d   = trunc_q;
    valid_d   = valid_q;
`ifdef TOKEN_SEQUENCER_NEG_NUM_EN
    neg_d     = neg_q;
`endif
    if (i_en) begin
      case (state_q)
        FETCH: begin
          if (i_tok_ready) begin
            cap_dat_d = i_tok_data;
            cap_eol_d = i_tok_eol;
            cap_wc_d  = i_tok_wc;
            state_d   = ACK;
          end
        end
        ACK: begin
          // Four-phase handshake: the byte is consumed once ready drops.
          if (!i_tok_ready) begin
            if (cap_eol_q) begin
              state_d = EMIT;
              valid_d = 1'b1;
              eol_d   = 1'b1;
            end else if (cap_wc_q) begin
              if (seen_q) begin
                state_d = EMIT;
                valid_d = 1'b1;
              end else begin
                state_d = FETCH;  // separator with nothing pending
              end
            end else begin
              state_d = FETCH;
              seen_d  = 1'b1;
              if (len_q < LW'(MAXLEN)) begin
                for (int i = 0; i < MAXLEN; i++) begin
                  if (LW'(i) == len_q) word_d[i*8 +: 8] = cap_dat_q;
                end
                len_d = len_q + LW'(1);
              end else begin
                trunc_d = 1'b1;
              end
              // Dropped characters still feed the numeric value.
              if (is_digit) begin
                num_d   = num_q * NUM_WIDTH'(10) + digit_val;
                digit_d = 1'b1;
              end else begin
`ifdef TOKEN_SEQUENCER_NEG_NUM_EN
                if ((cap_dat_q == 8'h2D) && !seen_q) neg_d = 1'b1;
                else is_num_d = 1'b0;
`else
                is_num_d = 1'b0;
`endif
              end
            end
          end
        end
        EMIT: begin
          if (i_accept) begin
            state_d  = FETCH;
            word_d   = '0;
            len_d    = '0;
            seen_d   = 1'b0;
            digit_d  = 1'b0;
            is_num_d = 1'b1;
            num_d    = '0;
            eol_d    = 1'b0;
            trunc_d  = 1'b0;
            valid_d  = 1'b0;
`ifdef TOKEN_SEQUENCER_NEG_NUM_EN
            neg_d    = 1'b0;
`endif
          end
        end
        default: state_d = FETCH;
      endcase
      next_d = (state_d != EMIT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= FETCH;
      next_q    <= 1'b0;
      cap_dat_q <= '0;
      cap_eol_q <= 1'b0;
      cap_wc_q  <= 1'b0;
      word_q    <= '0;
      len_q     <= '0;
      seen_q    <= 1'b0;
      digit_q   <= 1'b0;
      is_num_q  <= 1'b1;  // o_is_num still reads 0: no digit yet
      num_q     <= '0;
      eol_q     <= 1'b0;
      trunc_q   <= 1'b0;
      valid_q   <= 1'b0;
`ifdef TOKEN_SEQUENCER_NEG_NUM_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      next_q    <= next_d;
      cap_dat_q <= cap_dat_d;
      cap_eol_q <= cap_eol_d;
      cap_wc_q  <= cap_wc_d;
      word_q    <= word_d;
      len_q     <= len_d;
      seen_q    <= seen_d;
      digit_q   <= digit_d;
      is_num_q  <= is_num_d;
      num_q     <= num_d;
      eol_q     <= eol_d;
      trunc_q   <= trunc_d;
      valid_q   <= valid_d;
`ifdef TOKEN_SEQUENCER_NEG_NUM_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign o_next   = next_q & i_en;
  assign o_valid  = valid_q;
  assign o_word   = word_q;
  assign o_len    = len_q;
  assign o_is_num = is_num_q & digit_q;
`ifdef TOKEN_SEQUENCER_NEG_NUM_EN
  assign o_num    = neg_q ? (~num_q + NUM_WIDTH'(1)) : num_q;
`else
  assign o_num    = num_q;
`endif
  assign o_eol    = eol_q;
  assign o_trunc  = trunc_q;

endmodule

// File: doc/token_sequencer.md
TOKEN_SEQUENCER -- requirements
Module: token_sequencer

Interface
REQ-001 SHALL have parameter MAXLEN, default 8, maximum stored characters per token.
REQ-002 SHALL have parameter NUM_WIDTH, default 32, width of numeric value output.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_en, input, 1, enable; 0 freezes all state and forces o_next=0.
REQ-006 SHALL have port o_next, output, 1, fetch request to tokenizer.
REQ-007 SHALL have port i_tok_ready, input, 1, tokenizer byte-valid.
REQ-008 SHALL have port i_tok_data, input, 8, tokenizer byte.
REQ-009 SHALL have ports i_tok_eol and i_tok_wc, input, 1 each, tokenizer EOL / word-separator flags.
REQ-010 SHALL have port o_valid, output, 1, token available to parser.
REQ-011 SHALL have port i_accept, input, 1, parser consumes token.
REQ-012 SHALL have port o_word, output, 8*MAXLEN, token chars, first char in bits [7:0], unused bytes 0.
REQ-013 SHALL have port o_len, output, clog2(MAXLEN+1), stored char count.
REQ-014 SHALL have port o_is_num, output, 1, token is a decimal literal.
REQ-015 SHALL have port o_num, output, NUM_WIDTH, literal value.
REQ-016 SHALL have ports o_eol and o_trunc, output, 1 each, token ends line / token exceeded MAXLEN.

Function
REQ-017 SHALL implement states FETCH, ACK, EMIT; o_next registered, 1 in FETCH/ACK when i_en=1, 0 in EMIT.
REQ-018 FETCH: when i_tok_ready=1, SHALL register i_tok_data/i_tok_eol/i_tok_wc and go to ACK.
REQ-019 ACK: SHALL hold o_next=1 until i_tok_ready=0, then process the captured byte in that same cycle.
REQ-020 Data byte (neither flag): SHALL append at index o_len if o_len<MAXLEN, else drop it and set o_trunc; return to FETCH.
REQ-021 Arithmetic: digit '0'-'9' SHALL update num = num*10 + digit, modulo 2^NUM_WIDTH; any non-digit SHALL clear is_num.
REQ-022 is_num SHALL start 1 per token and be cleared if token has zero digits; dropped chars still update is_num/num.
REQ-023 WC byte with token length (incl. dropped) >0: SHALL go to EMIT with o_valid=1, o_eol=0; with length 0: discard, back to FETCH.
REQ-024 EOL byte: SHALL go to EMIT with o_valid=1, o_eol=1, regardless of length (empty EOL token has o_len=0, o_is_num=0).
REQ-025 o_valid SHALL rise the cycle after i_tok_ready falls in ACK (1-cycle latency from processing edge).
REQ-026 EMIT: all token outputs SHALL stay stable while o_valid=1 and i_accept=0.
REQ-027 EMIT with i_accept=1: SHALL clear o_valid, buffer, len, num, flags; is_num to 1; go to FETCH next cycle.
REQ-028 i_accept while o_valid=0 SHALL be ignored.
REQ-029 i_en=0 in any state SHALL hold state and all registers; resumes unchanged when i_en returns to 1.

Reset
REQ-030 i_rst=1 SHALL, on the next clock edge, force state FETCH and o_next=0, o_valid=0, o_word=0, o_len=0, o_is_num=0, o_num=0, o_eol=0, o_trunc=0.
REQ-031 Reset mid-token or mid-EMIT SHALL discard the partial/pending token without emitting it.
REQ-032 i_rst SHALL take priority over i_en and i_accept.

Configuration
REQ-033 Macro TOKEN_SEQUENCER_NEG_NUM_EN defined: leading '-' followed by >=1 digit SHALL yield o_is_num=1, o_num = two's-complement negation of digit value; lone "-" is a word.
REQ-034 Macro undefined: '-' SHALL be an ordinary non-digit (clears is_num); no negation logic built.

Verification
REQ-035 Feed "42 " -> one token o_word[15:0]="24" byte order '4','2', o_len=2, o_is_num=1, o_num=42, o_eol=0.
REQ-036 Feed "DUP\n" -> o_len=3, o_is_num=0, o_eol=1; then "\n" alone -> o_len=0, o_eol=1.
REQ-037 Feed "  a " (leading spaces) -> exactly one token 'a'; hold i_accept=0 10 cycles -> outputs stable, o_next=0.
REQ-038 MAXLEN=8, feed "123456789 " -> o_len=8, o_trunc=1, o_is_num=1, o_num=123456789.
REQ-039 With TOKEN_SEQUENCER_NEG_NUM_EN, "-7 " -> o_is_num=1, o_num=32'hFFFFFFF9; without, o_is_num=0, o_len=2.
REQ-040 Assert i_rst during ACK of 'x' in "ax " -> all outputs 0 next edge; following "b " yields token 'b' only.
